change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter: ACK_TIMEOUT, 255, max cycles in OFFER without coin_ack before fault.
REQ-002 Parameter: STOCK_W, 4, width of each coin stock counter.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to pay out amount_tens/amount_ones; sampled only in IDLE.
REQ-006 amount_tens, amount_ones  in  4 each  BCD change amount, 0..99 units.
REQ-007 refill_en  in  1; refill_type  in  2; refill_cnt  in  STOCK_W  add refill_cnt coins of refill_type to stock; accepted only in IDLE.
REQ-008 coin_ack  in  1  coin mechanism has taken the offered coin; ignored outside OFFER.
REQ-009 coin_valid  out  1; coin_type  out  2  coin offer (01=1, 10=5, 11=10, 00=none).
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done, err  out  1 each  one-cycle completion/fault pulses; err_code  out  2  01 bad BCD, 10 insufficient stock, 11 ack timeout.
REQ-012 rem_tens, rem_ones  out  4 each  remaining BCD amount; stock_1, stock_5, stock_10  out  STOCK_W each.

Function
REQ-013 States IDLE, SELECT, OFFER, DONE; all outputs registered.
REQ-014 IDLE + start: either digit >9 -> err pulse next cycle, err_code=01, stay IDLE, rem unchanged; else rem<=amount, err_code<=00, go SELECT.
REQ-015 SELECT: rem==00 -> DONE; else choose largest coin with stock>0 and value<=rem (10 needs tens>0; 5 needs tens>0 or ones>=5; 1 needs rem>0) -> OFFER with coin_valid=1, coin_type set.
REQ-016 SELECT, rem>0, no coin fits -> err pulse, err_code=10, IDLE, rem held showing unpaid balance.
REQ-017 OFFER: coin_valid and coin_type held stable until coin_ack sampled high; that edge: rem -= coin value (BCD with borrow), matching stock decrements, coin_valid low, go SELECT; min 2 cycles per coin.
REQ-018 BCD subtract: 10 -> tens-1; 5 -> ones>=5 ? ones-5 : ones+5 with tens-1; 1 -> ones>0 ? ones-1 : ones=9 with tens-1; rem never negative.
REQ-019 OFFER timeout counter clears on OFFER entry; reaching ACK_TIMEOUT without ack -> err pulse, err_code=11, coin_valid low, IDLE, stock and rem unchanged; ack in the timeout cycle wins.
REQ-020 DONE: done high exactly one cycle, then IDLE; amount 00 -> done two cycles after start, no coin offered.
REQ-021 start outside IDLE ignored; refill_en outside IDLE ignored.
REQ-022 Refill saturates at 2**STOCK_W-1; refill_type 00 ignored; simultaneous start+refill in IDLE both accepted, SELECT uses updated stock.
REQ-023 err_code holds until next accepted start.

Reset
REQ-024 rst_n low, at any time including mid-OFFER: state IDLE, coin_valid/done/err/busy=0, coin_type=00, err_code=00, rem=00, all stocks=0, timeout counter=0.
REQ-025 No coin is offered or stock changed in the first cycle after rst_n rises unless start/refill is applied.

Structure
REQ-026 Shared package change_pkg holds coin_type encodings, coin values, err_code encodings and state encoding.
REQ-027 Sub-module bcd2_sub (combinational 2-digit BCD minus coin value) instantiated once; FSM, counters, stocks in change_dispenser.

Verification
REQ-028 Stocks 10:3, 5:3, 1:5; start 27; ack each offer next cycle -> coins 10,10,5,1,1; done; rem 00; stocks 1,2,3.
REQ-029 Stocks 10:0, 5:4, 1:2; start 12 -> coins 5,5,1,1; rem sequence 12,07,02,01,00 (borrow checked); done.
REQ-030 start with tens=1, ones=A -> err pulse, err_code=01, coin_valid never high, busy stays low.
REQ-031 Stocks 5:1 only; start 08 -> coin 5 then err, err_code=10, rem 03, stock_5=0.
REQ-032 ACK_TIMEOUT=8, stock 1:1, start 01, no ack -> err after 8 OFFER cycles, err_code=11, stock_1=1, rem 01.
REQ-033 rst_n low while coin_valid=1 -> all outputs and stocks 0 immediately, then IDLE behaviour correct on restart.

Source files
------------

// File: rtl/change_pkg.sv
// Shared encodings for the change dispenser: coins, coin values,
// error codes and FSM states.
package change_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_5    = 2'b10;
  localparam logic [1:0] COIN_10   = 2'b11;

  localparam logic [3:0] VAL_1  = 4'd1;
  localparam logic [3:0] VAL_5  = 4'd5;
  // Ten as a packed two-digit BCD value.
  localparam logic [7:0] VAL_10 = 8'h10;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_BCD   = 2'b01;
  localparam logic [1:0] ERR_STOCK = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_OFFER  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/change_dispenser_if.sv
// Request, refill and coin-mechanism bundle of the change dispenser.
interface change_dispenser_if #(
  parameter int STOCK_W = 4
);
  logic               start;
  logic [3:0]         amount_tens;
  logic [3:0]         amount_ones;
  logic               refill_en;
  logic [1:0]         refill_type;
  logic [STOCK_W-1:0] refill_cnt;
  logic               coin_ack;
  logic               coin_valid;
  logic [1:0]         coin_type;
  logic               busy;
  logic               done;
  logic               err;
  logic [1:0]         err_code;
  logic [3:0]         rem_tens;
  logic [3:0]         rem_ones;
  logic [STOCK_W-1:0] stock_1;
  logic [STOCK_W-1:0] stock_5;
  logic [STOCK_W-1:0] stock_10;

  modport master (
    output start, amount_tens, amount_ones,
    output refill_en, refill_type, refill_cnt, coin_ack,
    input  coin_valid, coin_type, busy, done, err, err_code,
    input  rem_tens, rem_ones, stock_1, stock_5, stock_10
  );

  modport slave (
    input  start, amount_tens, amount_ones,
    input  refill_en, refill_type, refill_cnt, coin_ack,
    output coin_valid, coin_type, busy, done, err, err_code,
    output rem_tens, rem_ones, stock_1, stock_5, stock_10
  );
endinterface

// File: rtl/bcd2_sub.sv
// Two-digit BCD remainder minus one coin value; the caller
// guarantees the coin never exceeds the remainder.
module bcd2_sub
  import change_pkg::*;
(
  input  logic [3:0] i_tens,
  input  logic [3:0] i_ones,
  input  logic [1:0] i_coin,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  always_comb begin
    o_tens = i_tens;
    o_ones = i_ones;
    unique case (i_coin)
      COIN_10: {o_tens, o_ones} = {i_tens, i_ones} - VAL_10;
      COIN_5: begin
        if (i_ones >= VAL_5) begin
          o_ones = i_ones - VAL_5;
        end else begin
          // ones + 10 - 5 with a borrow from tens
          o_ones = i_ones + VAL_5;
          o_tens = i_tens - 4'd1;
        end
      end
      COIN_1: begin
        if (i_ones != 4'd0) begin
          o_ones = i_ones - VAL_1;
        end else begin
          o_ones = 4'd9;
          o_tens = i_tens - 4'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a BCD amount in 10/5/1 coins from
// refillable stock, one acknowledged coin offer at a time.
module change_dispenser
  import change_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int STOCK_W     = 4
) (
  input logic               clk,
  input logic               rst_n,
  change_dispenser_if.slave bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [1:0]         r_state;
  logic [TW-1:0]      r_tmo;
  logic               r_valid;
  logic [1:0]         r_type;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [1:0]         r_code;
  logic [3:0]         r_tens;
  logic [3:0]         r_ones;
  logic [STOCK_W-1:0] r_s1;
  logic [STOCK_W-1:0] r_s5;
  logic [STOCK_W-1:0] r_s10;

  logic [3:0] w_sub_tens;
  logic [3:0] w_sub_ones;
  logic       w_bad;
  logic       w_zero;
  logic       w_fit10;
  logic       w_fit5;
  logic       w_fit1;
  logic [1:0] w_sel;

  function automatic logic [STOCK_W-1:0] sat_add(
    input logic [STOCK_W-1:0] a,
    input logic [STOCK_W-1:0] b
  );
    logic [STOCK_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STOCK_W] ? '1 : s[STOCK_W-1:0];
  endfunction

  bcd2_sub u_sub (
    .i_tens (r_tens),
    .i_ones (r_ones),
    .i_coin (r_type),
    .o_tens (w_sub_tens),
    .o_ones (w_sub_ones)
  );

  assign w_bad   = (bus.amount_tens > 4'd9)
                || (bus.amount_ones > 4'd9);
  assign w_zero  = (r_tens == 4'd0) && (r_ones == 4'd0);
  assign w_fit10 = (r_s10 != '0) && (r_tens != 4'd0);
  assign w_fit5  = (r_s5 != '0)
                && ((r_tens != 4'd0) || (r_ones >= VAL_5));
  assign w_fit1  = (r_s1 != '0) && !w_zero;

  // Largest coin that both fits the remainder and is in stock.
  assign w_sel = w_fit10 ? COIN_10 :
                 w_fit5  ? COIN_5  :
                 w_fit1  ? COIN_1  : COIN_NONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tmo   <= '0;
      r_valid <= 1'b0;
      r_type  <= COIN_NONE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= ERR_NONE;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
      r_s1    <= '0;
      r_s5    <= '0;
      r_s10   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.refill_en) begin
            unique case (bus.refill_type)
              COIN_1:  r_s1  <= sat_add(r_s1, bus.refill_cnt);
              COIN_5:  r_s5  <= sat_add(r_s5, bus.refill_cnt);
              COIN_10: r_s10 <= sat_add(r_s10, bus.refill_cnt);
              default: ;
            endcase
          end
          if (bus.start) begin
            if (w_bad) begin
              r_err  <= 1'b1;
              r_code <= ERR_BCD;
            end else begin
              r_tens  <= bus.amount_tens;
              r_ones  <= bus.amount_ones;
              r_code  <= ERR_NONE;
              r_busy  <= 1'b1;
              r_state <= ST_SELECT;
            end
          end
        end
        ST_SELECT: begin
          if (w_zero) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_sel != COIN_NONE) begin
            r_valid <= 1'b1;
            r_type  <= w_sel;
            r_tmo   <= '0;
            r_state <= ST_OFFER;
          end else begin
            r_err   <= 1'b1;
            r_code  <= ERR_STOCK;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_OFFER: begin
          if (bus.coin_ack) begin
            r_tens  <= w_sub_tens;
            r_ones  <= w_sub_ones;
            r_valid <= 1'b0;
            r_type  <= COIN_NONE;
            r_state <= ST_SELECT;
            unique case (r_type)
              COIN_1:  r_s1  <= r_s1 - 1'b1;
              COIN_5:  r_s5  <= r_s5 - 1'b1;
              COIN_10: r_s10 <= r_s10 - 1'b1;
              default: ;
            endcase
          end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_code  <= ERR_TMO;
            r_valid <= 1'b0;
            r_type  <= COIN_NONE;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.coin_valid = r_valid;
  assign bus.coin_type  = r_type;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.err_code   = r_code;
  assign bus.rem_tens   = r_tens;
  assign bus.rem_ones   = r_ones;
  assign bus.stock_1    = r_s1;
  assign bus.stock_5    = r_s5;
  assign bus.stock_10   = r_s10;

endmodule
